sdp_y_alu_in_arb: RTL

SDP_Y_ALU_IN_ARB -- requirements
Module: sdp_y_alu_in_arb

---
 rtl/sdp_y_alu_pkg.sv | 16 +
 rtl/sdp_y_alu_in_pipe.sv | 41 ++++
 rtl/sdp_y_alu_in_arb.sv | 110 +++++++++++
 3 files changed

// File: rtl/sdp_y_alu_pkg.sv
// Shared definitions for the SDP Y ALU input arbiter.
//   arb_state_e : arbiter FSM states (IDLE / GRANT0 / GRANT1)
//   DATA_W_DEF  : default payload width for every channel
//   CNT_W       : width of the per-grant beat counter
package sdp_y_alu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    localparam int DATA_W_DEF = 128;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/sdp_y_alu_in_pipe.sv
// Single-stage valid/ready holding register with stall hold.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_vld/in_rdy/in_pd/in_src : upstream beat and its requester index
//   out_vld/out_rdy/out_pd/out_src : registered downstream beat
// in_rdy is high when the register is empty or draining this cycle, so a
// drain and a refill in the same cycle keep out_vld high with no bubble.
module sdp_y_alu_in_pipe
    import sdp_y_alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [DATA_W-1:0] in_pd,
    input  logic              in_src,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DATA_W-1:0] out_pd,
    output logic              out_src
);

    assign in_rdy = !out_vld || out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_pd  <= '0;
            out_src <= 1'b0;
        end else if (in_vld && in_rdy) begin
            out_vld <= 1'b1;
            out_pd  <= in_pd;
            out_src <= in_src;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/sdp_y_alu_in_arb.sv
// Two-requester arbiter feeding the SDP Y ALU input channel.
// Ports:
//   nvdla_core_clk, nvdla_core_rst : clock, asynchronous active-high reset
//   req0_*  : operand stream (valid/ready/payload)
//   req1_*  : bypass/constant stream (valid/ready/payload)
//   chn_alu_in_* : arbitrated, registered output channel; _src is the
//                  requester index of the beat on _pd
//   arb_busy : high while a grant is held
// A grant lasts up to BURST_LEN accepted beats or until the granted
// requester drops valid; IDLE then re-arbitrates one cycle later.
// Build option: SDP_Y_ALU_IN_ARB_STRICT_PRIO_EN makes requester 0 win every
// tie and removes the round-robin pointer.
module sdp_y_alu_in_arb
    import sdp_y_alu_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BURST_LEN = 4
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic              req0_vld,
    output logic              req0_rdy,
    input  logic [DATA_W-1:0] req0_pd,
    input  logic              req1_vld,
    output logic              req1_rdy,
    input  logic [DATA_W-1:0] req1_pd,
    output logic              chn_alu_in_vld,
    input  logic              chn_alu_in_rdy,
    output logic [DATA_W-1:0] chn_alu_in_pd,
    output logic              chn_alu_in_src,
    output logic              arb_busy
);

    arb_state_e        state, nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              accept_ok;
    logic              g_vld;
    logic [DATA_W-1:0] g_pd;
    logic              g_src;
    logic              acc;
    logic              tie_pick1;

`ifdef SDP_Y_ALU_IN_ARB_STRICT_PRIO_EN
    assign tie_pick1 = 1'b0;
`else
    logic rr_ptr;
    assign tie_pick1 = rr_ptr;
`endif

    assign arb_busy = (state != IDLE);
    assign req0_rdy = (state == GRANT0) && accept_ok;
    assign req1_rdy = (state == GRANT1) && accept_ok;

    assign g_src   = (state == GRANT1);
    assign g_vld   = arb_busy && (g_src ? req1_vld : req0_vld);
    assign g_pd    = g_src ? req1_pd : req0_pd;
    assign acc     = g_vld && accept_ok;
    assign cnt_inc = cnt + 1'b1;

    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req0_vld && req1_vld) nxt = tie_pick1 ? GRANT1 : GRANT0;
                else if (req0_vld)        nxt = GRANT0;
                else if (req1_vld)        nxt = GRANT1;
            end
            GRANT0, GRANT1: begin
                // Burst limit counts the beat accepted this cycle; a dropped
                // valid can never coincide with an accept.
                if ((acc && cnt_inc == CNT_W'(BURST_LEN)) || !g_vld) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            // Held at zero in IDLE so every grant starts from a clean count.
            if (state == IDLE) cnt <= '0;
            else if (acc)      cnt <= cnt_inc;
        end
    end

`ifndef SDP_Y_ALU_IN_ARB_STRICT_PRIO_EN
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst)              rr_ptr <= 1'b0;
        else if (arb_busy && nxt == IDLE) rr_ptr <= (state == GRANT0);
    end
`endif

    sdp_y_alu_in_pipe #(.DATA_W(DATA_W)) u_pipe (
        .clk     (nvdla_core_clk),
        .rst     (nvdla_core_rst),
        .in_vld  (g_vld),
        .in_rdy  (accept_ok),
        .in_pd   (g_pd),
        .in_src  (g_src),
        .out_vld (chn_alu_in_vld),
        .out_rdy (chn_alu_in_rdy),
        .out_pd  (chn_alu_in_pd),
        .out_src (chn_alu_in_src)
    );

endmodule
